// File: rtl/data_mem_responder.sv
// Data-memory responder: captures a load/store, waits LATENCY cycles, then performs
// a byte/half/word access on a word-organised RAM and pulses ready (and err on fault).
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic        ovr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int            LAT_LAST_I = (LATENCY > 0) ? (LATENCY - 1) : 0;
  localparam logic [3:0]    LAT_LAST   = LAT_LAST_I[3:0];
  localparam int            DEPTH      = 1 << ADDR_W;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                ovr_q, ovr_d;

  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [2:0]          f3_q;
  logic                load_q;
  logic                fault_q;

  logic                req;
  logic                capture;
  logic                go_access;
  logic [ADDR_W+1:0]   s_addr;
  logic [31:0]         s_wdata;
  logic [2:0]          s_f3;
  logic                s_load;
  logic                s_fault;
  logic [ADDR_W-1:0]   s_idx;
  logic [1:0]          s_lane;
  logic                mem_we;
  logic [3:0]          mem_be;
  logic [31:0]         mem_wd;
  logic [31:0]         mem_rd;

  logic [31:0]         mem [DEPTH];

  function automatic logic req_fault(input logic [31:0] a, input logic [2:0] f,
                                     input logic both);
    logic oor;
    logic mis;
    logic bad_f3;
    oor    = (a >> (ADDR_W + 2)) != 32'd0;
    mis    = ((f[1:0] == 2'b01) && a[0]) ||
             ((f[1:0] == 2'b10) && (a[1:0] != 2'b00));
    bad_f3 = (f == 3'b011) || (f == 3'b110) || (f == 3'b111);
    return oor | mis | bad_f3 | both;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f[1:0])
      2'b00:   return f[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return f[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] lane, input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] w, input logic [2:0] f);
    case (f[1:0])
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  assign req     = data_read | data_write;
  assign capture = (state_q == IDLE) && req;

  // With LATENCY=0 the access happens on the capture edge, so the request source
  // must bypass the latch registers while idle.
  always_comb begin
    if (state_q == IDLE) begin
      s_addr  = addr[ADDR_W+1:0];
      s_wdata = wdata;
      s_f3    = funct3;
      s_load  = data_read & ~data_write;
      s_fault = req_fault(addr, funct3, data_read & data_write);
    end else begin
      s_addr  = addr_q;
      s_wdata = wdata_q;
      s_f3    = f3_q;
      s_load  = load_q;
      s_fault = fault_q;
    end
  end

  assign s_idx  = s_addr[ADDR_W+1:2];
  assign s_lane = s_addr[1:0];
  assign mem_rd = mem[s_idx];
  assign mem_be = store_be(s_lane, s_f3);
  assign mem_wd = store_data(s_wdata, s_f3);
  assign mem_we = go_access && !s_load && !s_fault;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    go_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = 4'd0;
          if (LATENCY == 0) begin
            state_d   = ACCESS;
            go_access = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d   = ACCESS;
          go_access = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (go_access && s_load && !s_fault) begin
      rdata_d = load_ext(mem_rd, s_lane, s_f3);
    end
    err_d = go_access & s_fault;
    ovr_d = ovr_q | (req & (state_q != IDLE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  // Request latch: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_q  <= addr[ADDR_W+1:0];
      wdata_q <= wdata;
      f3_q    <= funct3;
      load_q  <= data_read & ~data_write;
      fault_q <= req_fault(addr, funct3, data_read & data_write);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && mem_be[i]) begin
        mem[s_idx][i*8 +: 8] <= mem_wd[i*8 +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = (state_q == ACCESS);
  assign err   = err_q;
  assign busy  = (state_q != IDLE);
  assign ovr   = ovr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances at LATENCY 1, 3 and 0.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] ad    [3];
  logic [31:0] wd    [3];
  logic [2:0]  f3    [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        err   [3];
  logic        busy  [3];
  logic        ovr   [3];

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder #(.ADDR_W(8), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst_n[0]), .data_read(rd[0]), .data_write(wr[0]), .addr(ad[0]),
    .wdata(wd[0]), .funct3(f3[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0]),
    .busy(busy[0]), .ovr(ovr[0]));

  data_mem_responder #(.ADDR_W(8), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst_n[1]), .data_read(rd[1]), .data_write(wr[1]), .addr(ad[1]),
    .wdata(wd[1]), .funct3(f3[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1]),
    .busy(busy[1]), .ovr(ovr[1]));

  data_mem_responder #(.ADDR_W(8), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst_n[2]), .data_read(rd[2]), .data_write(wr[2]), .addr(ad[2]),
    .wdata(wd[2]), .funct3(f3[2]), .rdata(rdata[2]), .ready(ready[2]), .err(err[2]),
    .busy(busy[2]), .ovr(ovr[2]));

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    logic [31:0] exp_q;
    logic        exp_e;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f, input logic [31:0] q, input logic e);
    vec_t v;
    v.r = r; v.w = w; v.a = a; v.d = d; v.f = f; v.exp_q = q; v.exp_e = e;
    tbl.push_back(v);
  endtask

  // One-cycle strobe; returns cycles from strobe to ready (0 if it never came).
  task automatic req(input int k, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] f,
                     output int cyc, output logic [31:0] q, output logic e);
    @(negedge clk);
    rd[k] = r; wr[k] = w; ad[k] = a; wd[k] = d; f3[k] = f;
    cyc = 0; q = 32'd0; e = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        rd[k] = 1'b0; wr[k] = 1'b0;
        chk($sformatf("dut%0d_busy_in_flight", k), {31'd0, busy[k]}, 32'd1);
      end
      if (ready[k]) begin
        cyc = i; q = rdata[k]; e = err[k];
        break;
      end
    end
    if (cyc != 0) begin
      @(negedge clk);
      chk($sformatf("dut%0d_ready_one_cycle", k), {31'd0, ready[k]}, 32'd0);
      chk($sformatf("dut%0d_busy_after", k), {31'd0, busy[k]}, 32'd0);
    end
  endtask

  initial begin
    int          cyc;
    logic [31:0] q;
    logic        e;
    int          first;
    int          npulse;
    logic        saw;

    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0;
      ad[k] = 32'd0; wd[k] = 32'd0; f3[k] = 3'b010;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_rdata", k), rdata[k], 32'd0);
      chk($sformatf("rst%0d_flags", k), {28'd0, ready[k], err[k], busy[k], ovr[k]}, 32'd0);
    end
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    chk("post_rst_flags", {28'd0, ready[0], err[0], busy[0], ovr[0]}, 32'd0);

    // LATENCY=1 functional table
    add(0, 1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h00000000, 0);
    add(1, 0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 0);
    add(0, 1, 32'h20,  32'h80FF7F01, 3'b010, 32'hDEADBEEF, 0);
    add(1, 0, 32'h23,  32'h0,        3'b000, 32'hFFFFFF80, 0);
    add(1, 0, 32'h23,  32'h0,        3'b100, 32'h00000080, 0);
    add(1, 0, 32'h20,  32'h0,        3'b001, 32'h00007F01, 0);
    add(1, 0, 32'h22,  32'h0,        3'b101, 32'h000080FF, 0);
    add(1, 0, 32'h20,  32'h0,        3'b000, 32'h00000001, 0);
    add(0, 1, 32'h30,  32'h11223344, 3'b010, 32'h00000001, 0);
    add(0, 1, 32'h31,  32'h000000AA, 3'b000, 32'h00000001, 0);
    add(0, 1, 32'h32,  32'h0000BEEF, 3'b001, 32'h00000001, 0);
    add(1, 0, 32'h30,  32'h0,        3'b010, 32'hBEEFAA44, 0);
    add(1, 0, 32'h21,  32'h0,        3'b001, 32'hBEEFAA44, 1);
    add(1, 0, 32'h22,  32'h0,        3'b010, 32'hBEEFAA44, 1);
    add(1, 0, 32'h400, 32'h0,        3'b010, 32'hBEEFAA44, 1);
    add(1, 0, 32'h30,  32'h0,        3'b011, 32'hBEEFAA44, 1);
    add(1, 1, 32'h30,  32'hFFFFFFFF, 3'b010, 32'hBEEFAA44, 1);
    add(0, 1, 32'h22,  32'h12345678, 3'b010, 32'hBEEFAA44, 1);
    add(0, 1, 32'h410, 32'hCAFEF00D, 3'b010, 32'hBEEFAA44, 1);
    add(1, 0, 32'h30,  32'h0,        3'b010, 32'hBEEFAA44, 0);
    add(1, 0, 32'h20,  32'h0,        3'b010, 32'h80FF7F01, 0);
    add(1, 0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      req(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].f, cyc, q, e);
      chk($sformatf("v%0d_latency", i), cyc, 32'd2);
      chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, tbl[i].exp_e});
      chk($sformatf("v%0d_rdata", i), q, tbl[i].exp_q);
    end
    chk("lat1_no_ovr", {31'd0, ovr[0]}, 32'd0);

    // LATENCY=3: strobe held for two cycles -> one request, overrun flagged
    @(negedge clk);
    wr[1] = 1'b1; ad[1] = 32'h8; wd[1] = 32'h0BADF00D; f3[1] = 3'b010;
    first = 0; npulse = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) chk("ovr_before_second", {31'd0, ovr[1]}, 32'd0);
      if (i == 2) begin
        wr[1] = 1'b0;
        chk("ovr_set", {31'd0, ovr[1]}, 32'd1);
      end
      if (ready[1]) begin
        npulse++;
        if (first == 0) first = i;
      end
    end
    chk("lat3_first_ready", first, 32'd4);
    chk("lat3_ready_count", npulse, 32'd1);
    req(1, 1'b1, 1'b0, 32'h8, 32'h0, 3'b010, cyc, q, e);
    chk("lat3_load_latency", cyc, 32'd4);
    chk("lat3_load_rdata", q, 32'h0BADF00D);
    chk("ovr_sticky", {31'd0, ovr[1]}, 32'd1);

    // Reset in WAIT aborts a store
    req(1, 1'b0, 1'b1, 32'h40, 32'h0, 3'b010, cyc, q, e);
    chk("preload_latency", cyc, 32'd4);
    @(negedge clk);
    wr[1] = 1'b1; ad[1] = 32'h40; wd[1] = 32'h55; f3[1] = 3'b010;
    @(negedge clk);
    wr[1] = 1'b0;
    chk("mid_busy", {31'd0, busy[1]}, 32'd1);
    rst_n[1] = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy[1]}, 32'd0);
    saw = ready[1];
    repeat (5) begin
      @(negedge clk);
      saw = saw | ready[1];
    end
    chk("abort_no_ready", {31'd0, saw}, 32'd0);
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("abort_ovr_cleared", {31'd0, ovr[1]}, 32'd0);
    chk("abort_rdata_cleared", rdata[1], 32'd0);
    req(1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b010, cyc, q, e);
    chk("abort_load_latency", cyc, 32'd4);
    chk("abort_load_rdata", q, 32'h0);
    chk("abort_load_err", {31'd0, e}, 32'd0);

    // LATENCY=0
    req(2, 1'b0, 1'b1, 32'h4, 32'h13579BDF, 3'b010, cyc, q, e);
    chk("lat0_store_latency", cyc, 32'd1);
    req(2, 1'b1, 1'b0, 32'h4, 32'h0, 3'b010, cyc, q, e);
    chk("lat0_load_latency", cyc, 32'd1);
    chk("lat0_load_rdata", q, 32'h13579BDF);
    req(2, 1'b1, 1'b0, 32'h6, 32'h0, 3'b101, cyc, q, e);
    chk("lat0_lhu_rdata", q, 32'h00001357);
    req(2, 1'b1, 1'b0, 32'h5, 32'h0, 3'b001, cyc, q, e);
    chk("lat0_fault_err", {31'd0, e}, 32'd1);
    chk("lat0_fault_rdata", q, 32'h00001357);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Data-memory responder on the far side of the multicycle core's `data_read`/`data_write` strobes. It owns a word-organised data RAM. It samples a load or store request, waits a programmable number of cycles, then performs byte, half-word or word access selected by `funct3`, with sign or zero extension on loads. It returns `rdata` and a one-cycle `ready` pulse to the control/datapath.

Parameters:
ADDR_W, 8, word-address width; RAM holds 2^ADDR_W 32-bit words
LATENCY, 1, wait cycles between request capture and access (0..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
data_read  input  1  load request strobe (may be one cycle wide)
data_write  input  1  store request strobe (may be one cycle wide)
addr  input  32  byte address (ALU result)
wdata  input  32  store data (rs2)
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
rdata  output  32  load result, held until next successful load
ready  output  1  one-cycle pulse on completion of any accepted request
err  output  1  one-cycle pulse with ready when the request faulted
busy  output  1  high while a request is in flight
ovr  output  1  sticky: a request arrived while busy; cleared only by reset

Behaviour:
- Reset (rst=0, async) drives the FSM to IDLE, wait counter to 0, and rdata/ready/err/busy/ovr to 0. RAM contents are not reset.
- States are IDLE, WAIT and ACCESS.
- IDLE:
  - If `data_read` or `data_write` is high at a clock edge, latch addr, wdata, funct3 and the op into internal registers, and set busy=1.
  - Go to WAIT if LATENCY>0, else go to ACCESS.
- WAIT: the counter counts LATENCY cycles, then the FSM goes to ACCESS. Inputs are ignored during WAIT.
- ACCESS lasts one cycle, during which ready=1 and the access is performed using the latched values. The FSM then returns to IDLE with busy=0.
- Latency: a request sampled at edge N gives ready high in cycle N+LATENCY+1.
- Word index = addr[ADDR_W+1:2]; byte lane = addr[1:0].
- Fault cases. A request faults if any of the following holds:
  - addr[31:ADDR_W+2] is nonzero (out of range).
  - Half access with addr[0]=1.
  - Word access with addr[1:0] nonzero.
  - funct3 is 011, 110 or 111.
  - `data_read` and `data_write` were both high at capture.
- A faulting request still completes with ready=1 and err=1. RAM and rdata are unchanged.
- Store:
  - SB writes only lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all lanes.
  - Other bytes of the word are preserved. rdata is unchanged.
- Load:
  - Select the byte or half-word from the addressed lane and right-justify it.
  - B and H sign-extend from bit 7 or bit 15; BU and HU zero-extend; W passes through.
  - rdata updates in the ACCESS cycle (registered, visible with ready) and holds until the next successful load.
- Any `data_read`/`data_write` high in a cycle where busy=1 is dropped and sets ovr=1. The in-flight request is unaffected.
- A new request may be captured on the edge ending the ACCESS cycle only if it arrives in IDLE. Requests arriving during ACCESS count as an overrun.
- Reset asserted mid-request aborts it:
  - No ready is produced.
  - A store not yet in ACCESS does not modify RAM.
  - busy returns to 0 immediately.
- Strobes that are held high for several cycles are captured once. Later cycles within the same request count as an overrun.

Test Plan:
- SW then LW, LATENCY=1: write 0xDEADBEEF to addr 0x10, then read 0x10 -> ready exactly 2 cycles after each strobe; rdata=0xDEADBEEF, err=0.
- Byte/half extension: after SW 0x80FF7F01 at 0x20:
  - LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080.
  - LH 0x20 -> 0x00007F01; LHU 0x22 -> 0x000080FF; LB 0x20 -> 0x00000001.
- Partial store: SW 0x11223344 at 0x30, then SB 0xAA at 0x31, then SH 0xBEEF at 0x32 -> LW 0x30 returns 0xBEEFAA44.
- Faults: each case below gives ready=1, err=1 and no change to RAM or rdata.
  - LH at 0x21; LW at 0x22.
  - Address 0x00000400 with ADDR_W=8.
  - funct3=011.
  - Both strobes high.
- Overrun and latency: with LATENCY=3, a second strobe 1 cycle after the first -> ovr=1 and stays 1. A single ready appears 4 cycles after the first strobe. Sweep LATENCY=0 to get ready 1 cycle after the strobe.
- Reset mid-operation: SW 0x55 at 0x40 with LATENCY=3, then rst=0 in the WAIT state -> busy=0 and no ready. After release, LW 0x40 returns the prior contents (preload 0x0).
